cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Arbitrates functional-unit completions onto the single completion broadcast bus (CDB).
- The CDB feeds the ROB done/branch-taken port, the PRF valid bits and the RS wakeup.
- One completion is granted per cycle. Round-robin fairness, branch-first priority and an anti-starvation override decide the winner.
- Completions on a mispredicted path are killed before and after the output register.

Parameters:
NUM_REQ, 4, number of completing FUs (ALU, MULT, LD, BR).
ROB_IDX_W, 5, ROB entry index width (32-entry ROB).
PRF_IDX_W, 6, physical register tag width.
BR_MASK_W, 4, in-flight branch mask width.
STARVE_LIM, 3, cycles a non-branch requester may lose to branch priority before it is forced.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid_i  in  NUM_REQ  FU has a completed result
req_rob_idx_i  in  NUM_REQ x ROB_IDX_W  ROB entry of the result
req_tag_i  in  NUM_REQ x PRF_IDX_W  destination physical tag
req_br_flag_i  in  NUM_REQ  result is a branch
req_br_taken_i  in  NUM_REQ  resolved branch direction
req_br_mask_i  in  NUM_REQ x BR_MASK_W  branches this result depends on
req_ready_o  out  NUM_REQ  request consumed this cycle (granted or killed)
squash_i  in  1  branch misprediction recovery this cycle
squash_mask_i  in  BR_MASK_W  one-hot bit of the mispredicted branch
cdb_valid_o  out  1  broadcast valid
cdb_rob_idx_o  out  ROB_IDX_W  to ROB fu2rob index
cdb_tag_o  out  PRF_IDX_W  to PRF/RS wakeup
cdb_br_flag_o  out  1  broadcast is a branch
cdb_br_taken_o  out  1  to ROB branch-taken
cdb_br_mask_o  out  BR_MASK_W  mask of the broadcast entry

Behaviour:
- Reset: all output-stage registers 0; cdb_valid_o=0; rr_ptr=0; all starve counters 0; req_ready_o=0.
- Handshake:
  - Transfer occurs when req_valid_i[i] & req_ready_o[i].
  - req_ready_o is combinational from the current valid inputs and state.
  - The FU holds its payload stable while valid & ~ready.
- Kill:
  - kill[i] = squash_i & |(req_br_mask_i[i] & squash_mask_i).
  - A killed request gets req_ready_o[i]=1 (dropped), never enters arbitration and is never broadcast.
- Eligible set: elig[i] = req_valid_i[i] & ~kill[i].
- Winner selection, in priority order:
  - (a) Force: if any eligible requester has starve_cnt == STARVE_LIM, the lowest such index at or after rr_ptr wins.
  - (b) Branch priority: otherwise, if any eligible requester has br_flag, the first such at or after rr_ptr (circular) wins.
  - (c) Otherwise the first eligible at or after rr_ptr wins.
  - Exactly one grant per cycle; req_ready_o[winner]=1.
- rr_ptr update: on any grant, rr_ptr <= (winner+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Starve counter, per requester:
  - Increments (saturating at STARVE_LIM) when elig, ~br_flag, not granted, and the winner is a branch.
  - Clears on grant or when not valid.
- Latency: one cycle. The grant's payload is registered into the output stage and cdb_valid_o rises the next cycle.
- Output kill:
  - cdb_valid_o = valid_r & ~(squash_i & |(br_mask_r & squash_mask_i)). This kills a registered result made stale by a same-cycle squash.
  - Data outputs stay driven from the registers regardless of kill.
- Mask maintenance: a registered br_mask_r is not cleared on correct prediction. Squash uses a one-hot match only.
- No grant in a cycle: valid_r <= 0. Data registers hold.
- Simultaneous squash and grant: the winner is chosen only from non-killed requests in the same cycle.
- Reset mid-operation: pending requests are not acknowledged, and the output register is cleared.

Decomposition:
- Shared package holds the CDB packet typedef cdb_pkt_t {valid, rob_idx, tag, br_flag, br_taken, br_mask}.
- It also holds the ROB_IDX_W/PRF_IDX_W/BR_MASK_W constants, so the ROB, RS and PRF consume the same type.
- One sub-module: rr_pick. It is a circular first-one finder taking a NUM_REQ bit vector and a start pointer and returning index + found. It is instantiated three times (force, branch, all).

Test Plan:
- Single ALU request idx=7 tag=33 after reset -> ready[0] same cycle; next cycle cdb_valid=1, rob_idx=7, tag=33; cycle after, cdb_valid=0.
- All 4 non-branch valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each requester's ready pulses once per 4 cycles.
- ALU(0) non-branch and BR(3) branch both valid, BR re-requests every cycle -> BR wins 3 times, then ALU is forced on the 4th cycle (starve_cnt=3); rr_ptr becomes 1.
- squash_i with mask 4'b0010; LD(2) holds br_mask=4'b0011, MULT(1) holds 4'b0001 -> ready[2]=1 with no broadcast, MULT granted, cdb_rob_idx=MULT's idx next cycle.
- Registered output br_mask_r=4'b0100 and squash_i with mask 4'b0100 in the broadcast cycle -> cdb_valid_o=0 that cycle.
- rst asserted while 3 requests are pending and an output is valid -> cdb_valid_o=0 next cycle, all ready=0 during reset, arbitration restarts at index 0 after release.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_pkg
// Description : Widths and the CDB packet type used by the completion
//               arbiter and by the ROB, RS and PRF that listen to the CDB.
// Revision    : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

    localparam int ROB_IDX_W = 5;
    localparam int PRF_IDX_W = 6;
    localparam int BR_MASK_W = 4;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PRF_IDX_W-1:0] tag;
        logic                 br_flag;
        logic                 br_taken;
        logic [BR_MASK_W-1:0] br_mask;
    } cdb_pkt_t;

    // True when an entry depends on the branch being squashed.
    function automatic logic mask_hit(input logic [BR_MASK_W-1:0] mask,
                                      input logic [BR_MASK_W-1:0] squash_mask);
        return |(mask & squash_mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_if
// Description : FU completion requests, squash input and CDB broadcast.
//               master = FU/recovery side, slave = arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]                req_valid_i;
    logic [NUM_REQ-1:0][ROB_IDX_W-1:0] req_rob_idx_i;
    logic [NUM_REQ-1:0][PRF_IDX_W-1:0] req_tag_i;
    logic [NUM_REQ-1:0]                req_br_flag_i;
    logic [NUM_REQ-1:0]                req_br_taken_i;
    logic [NUM_REQ-1:0][BR_MASK_W-1:0] req_br_mask_i;
    logic [NUM_REQ-1:0]                req_ready_o;
    logic                              squash_i;
    logic [BR_MASK_W-1:0]              squash_mask_i;
    logic                              cdb_valid_o;
    logic [ROB_IDX_W-1:0]              cdb_rob_idx_o;
    logic [PRF_IDX_W-1:0]              cdb_tag_o;
    logic                              cdb_br_flag_o;
    logic                              cdb_br_taken_o;
    logic [BR_MASK_W-1:0]              cdb_br_mask_o;

    modport master (
        output req_valid_i, req_rob_idx_i, req_tag_i, req_br_flag_i,
               req_br_taken_i, req_br_mask_i, squash_i, squash_mask_i,
        input  req_ready_o, cdb_valid_o, cdb_rob_idx_o, cdb_tag_o,
               cdb_br_flag_o, cdb_br_taken_o, cdb_br_mask_o
    );

    modport slave (
        input  req_valid_i, req_rob_idx_i, req_tag_i, req_br_flag_i,
               req_br_taken_i, req_br_mask_i, squash_i, squash_mask_i,
        output req_ready_o, cdb_valid_o, cdb_rob_idx_o, cdb_tag_o,
               cdb_br_flag_o, cdb_br_taken_o, cdb_br_mask_o
    );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_rr_pick
// Description : Circular first-one finder: first set bit of i_vec at or
//               after i_start, wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter_rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  wire logic [N-1:0]     i_vec,
    input  wire logic [PTR_W-1:0] i_start,
    output logic      [PTR_W-1:0] o_idx,
    output logic                  o_found
);
    int               w_pos;
    logic [PTR_W-1:0] w_idx;

    // Scan offsets from farthest to nearest so the nearest hit is kept last.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_pos   = 0;
        w_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = int'(i_start) + k;
            if (w_pos >= N) w_pos = w_pos - N;
            w_idx = PTR_W'(w_pos);
            if (i_vec[w_idx]) begin
                o_idx   = w_idx;
                o_found = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Grants one FU completion per cycle onto the CDB. Starved
//               requesters are forced first, then branches, then plain
//               round-robin. Squashed entries are dropped on both sides of
//               the output register.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int STARVE_LIM = 3
) (
    input  wire logic   clk,
    input  wire logic   rst,
    cdb_arbiter_if.slave bus
);
    localparam int c_PTR_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(STARVE_LIM + 1);

    logic [NUM_REQ-1:0] w_kill;
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_force_vec;
    logic [NUM_REQ-1:0] w_br_vec;
    logic [NUM_REQ-1:0] w_grant_vec;
    logic [c_CNT_W-1:0] r_starve [NUM_REQ];
    logic [c_PTR_W-1:0] r_rr_ptr;
    logic [c_PTR_W-1:0] w_force_idx, w_br_idx, w_all_idx, w_winner;
    logic               w_force_found, w_br_found, w_grant;
    logic               w_win_br;
    cdb_pkt_t           r_pkt;

    // Per-requester kill, eligibility and starvation bookkeeping.
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
            assign w_kill[i]      = bus.squash_i & mask_hit(bus.req_br_mask_i[i], bus.squash_mask_i);
            assign w_elig[i]      = bus.req_valid_i[i] & ~w_kill[i];
            assign w_force_vec[i] = w_elig[i] & (r_starve[i] == c_CNT_W'(STARVE_LIM));
            assign w_br_vec[i]    = w_elig[i] & bus.req_br_flag_i[i];

            // Count cycles lost to a branch winner; clear on grant or idle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_starve[i] <= '0;
                end else if (w_grant_vec[i] || !bus.req_valid_i[i]) begin
                    r_starve[i] <= '0;
                end else if (w_elig[i] && !bus.req_br_flag_i[i] && w_grant && w_win_br &&
                             r_starve[i] != c_CNT_W'(STARVE_LIM)) begin
                    r_starve[i] <= r_starve[i] + 1'b1;
                end
            end
        end
    endgenerate

    cdb_arbiter_rr_pick #(.N(NUM_REQ), .PTR_W(c_PTR_W)) u_pick_force (
        .i_vec(w_force_vec), .i_start(r_rr_ptr), .o_idx(w_force_idx), .o_found(w_force_found)
    );
    cdb_arbiter_rr_pick #(.N(NUM_REQ), .PTR_W(c_PTR_W)) u_pick_br (
        .i_vec(w_br_vec), .i_start(r_rr_ptr), .o_idx(w_br_idx), .o_found(w_br_found)
    );
    cdb_arbiter_rr_pick #(.N(NUM_REQ), .PTR_W(c_PTR_W)) u_pick_all (
        .i_vec(w_elig), .i_start(r_rr_ptr), .o_idx(w_all_idx), .o_found(w_grant)
    );

    // Force beats branch priority, which beats plain round-robin.
    always_comb begin
        w_winner = w_all_idx;
        if (w_force_found)   w_winner = w_force_idx;
        else if (w_br_found) w_winner = w_br_idx;
    end

    assign w_win_br = bus.req_br_flag_i[w_winner];

    // One-hot grant and ready: granted or dropped, nothing while in reset.
    always_comb begin
        w_grant_vec = '0;
        if (w_grant) w_grant_vec[w_winner] = 1'b1;
        bus.req_ready_o = rst ? '0 : ((bus.req_valid_i & w_kill) | w_grant_vec);
    end

    // Round-robin pointer moves just past the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= (w_winner == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
        end
    end

    // Output stage: valid follows the grant, payload holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt <= '0;
        end else begin
            r_pkt.valid <= w_grant;
            if (w_grant) begin
                r_pkt.rob_idx  <= bus.req_rob_idx_i[w_winner];
                r_pkt.tag      <= bus.req_tag_i[w_winner];
                r_pkt.br_flag  <= bus.req_br_flag_i[w_winner];
                r_pkt.br_taken <= bus.req_br_taken_i[w_winner];
                r_pkt.br_mask  <= bus.req_br_mask_i[w_winner];
            end
        end
    end

    // A squash arriving in the broadcast cycle still kills a stale result.
    assign bus.cdb_valid_o    = r_pkt.valid & ~(bus.squash_i & mask_hit(r_pkt.br_mask, bus.squash_mask_i));
    assign bus.cdb_rob_idx_o  = r_pkt.rob_idx;
    assign bus.cdb_tag_o      = r_pkt.tag;
    assign bus.cdb_br_flag_o  = r_pkt.br_flag;
    assign bus.cdb_br_taken_o = r_pkt.br_taken;
    assign bus.cdb_br_mask_o  = r_pkt.br_mask;
endmodule
`default_nettype wire
